// File: rtl/bitty_alu_sequencer.sv
// bitty_alu_sequencer
//   Multi-cycle control sequencer for the BittyPro 16-bit arithmetic unit. Accepts one encoded
//   instruction per handshake, fetches two operands from an internal register file, drives the
//   (purely combinational) arithmetic unit, captures its outputs, then writes back and updates
//   flags. One instruction every four cycles: IDLE -> OPS -> EXEC -> WB -> IDLE.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   instr_valid_i/ready_o   instruction handshake; ready only in IDLE
//   instr_i                 [15:13] rx, [12:10] ry, [9:6] select, [5] use_carry, [4] no_wb
//   host_we_i/addr/wdata    direct register write, accepted in any cycle
//   dbg_addr_i/rdata_o      combinational register file read
//   alu_*_o                 registered select/operands/carry-in to the arithmetic unit
//   alu_*_i                 arithmetic unit result, carry and equality outputs
//   busy_o, done_o          not-idle indicator, one-cycle pulse in WB
//   result_o, flag_*_o      last captured result and flags

module bitty_alu_sequencer #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned REG_AW   = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic [15:0]       instr_i,
  input  logic              host_we_i,
  input  logic [REG_AW-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  input  logic [REG_AW-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic [3:0]        alu_select_o,
  output logic [DATA_W-1:0] alu_in_a_o,
  output logic [DATA_W-1:0] alu_in_b_o,
  output logic              alu_carry_in_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_carry_out_i,
  input  logic              alu_compare_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic              flag_carry_o,
  output logic              flag_eq_o,
  output logic              flag_zero_o
);

  typedef enum logic [1:0] {StIdle, StOps, StExec, StWb} state_e;

  state_e state_q, state_d;

  // Latched instruction fields
  logic [REG_AW-1:0] rx_q, rx_d, ry_q, ry_d;
  logic [3:0]        sel_q, sel_d;
  logic              use_carry_q, use_carry_d;
  logic              no_wb_q, no_wb_d;

  // Arithmetic unit drive registers
  logic [3:0]        alu_sel_q, alu_sel_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic              alu_cin_q, alu_cin_d;

  // Captured result and flags
  logic [DATA_W-1:0] result_q, result_d;
  logic              flag_carry_q, flag_carry_d;
  logic              flag_eq_q, flag_eq_d;
  logic              flag_zero_q, flag_zero_d;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Low instruction bits carry no meaning for this unit.
  logic unused_instr;
  assign unused_instr = ^instr_i[3:0];

  always_comb begin
    state_d      = state_q;
    rx_d         = rx_q;
    ry_d         = ry_q;
    sel_d        = sel_q;
    use_carry_d  = use_carry_q;
    no_wb_d      = no_wb_q;
    alu_sel_d    = alu_sel_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cin_d    = alu_cin_q;
    result_d     = result_q;
    flag_carry_d = flag_carry_q;
    flag_eq_d    = flag_eq_q;
    flag_zero_d  = flag_zero_q;
    regs_d       = regs_q;

    if (host_we_i) begin
      regs_d[host_addr_i] = host_wdata_i;
    end

    unique case (state_q)
      StIdle: begin
        if (instr_valid_i) begin
          rx_d        = instr_i[15:13];
          ry_d        = instr_i[12:10];
          sel_d       = instr_i[9:6];
          use_carry_d = instr_i[5];
          no_wb_d     = instr_i[4];
          state_d     = StOps;
        end
      end
      StOps: begin
        // Operands read pre-edge values, so a same-cycle host write is not seen here.
        alu_a_d   = regs_q[rx_q];
        alu_b_d   = regs_q[ry_q];
        alu_sel_d = sel_q;
        alu_cin_d = use_carry_q & flag_carry_q;
        state_d   = StExec;
      end
      StExec: begin
        result_d     = alu_result_i;
        flag_carry_d = alu_carry_out_i;
        flag_eq_d    = alu_compare_i;
        flag_zero_d  = (alu_result_i == '0);
        state_d      = StWb;
      end
      StWb: begin
        // Applied after the host write so writeback wins on an address collision.
        if (!no_wb_q) begin
          regs_d[rx_q] = result_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      rx_q         <= '0;
      ry_q         <= '0;
      sel_q        <= '0;
      use_carry_q  <= 1'b0;
      no_wb_q      <= 1'b0;
      alu_sel_q    <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
      result_q     <= '0;
      flag_carry_q <= 1'b0;
      flag_eq_q    <= 1'b0;
      flag_zero_q  <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      rx_q         <= rx_d;
      ry_q         <= ry_d;
      sel_q        <= sel_d;
      use_carry_q  <= use_carry_d;
      no_wb_q      <= no_wb_d;
      alu_sel_q    <= alu_sel_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cin_q    <= alu_cin_d;
      result_q     <= result_d;
      flag_carry_q <= flag_carry_d;
      flag_eq_q    <= flag_eq_d;
      flag_zero_q  <= flag_zero_d;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign instr_ready_o  = (state_q == StIdle);
  assign busy_o         = (state_q != StIdle);
  assign done_o         = (state_q == StWb);
  assign dbg_rdata_o    = regs_q[dbg_addr_i];
  assign alu_select_o   = alu_sel_q;
  assign alu_in_a_o     = alu_a_q;
  assign alu_in_b_o     = alu_b_q;
  assign alu_carry_in_o = alu_cin_q;
  assign result_o       = result_q;
  assign flag_carry_o   = flag_carry_q;
  assign flag_eq_o      = flag_eq_q;
  assign flag_zero_o    = flag_zero_q;

endmodule

// File: tb/tb_bitty_alu_sequencer.sv
// Self-checking bench for bitty_alu_sequencer: a stand-in combinational arithmetic unit, a
// transaction-level reference model, a per-cycle compare process, directed scenarios with
// literal expectations, and a randomized phase.

module tb_bitty_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        host_we;
  logic [2:0]  host_addr;
  logic [15:0] host_wdata;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_rdata;
  logic [3:0]  alu_select;
  logic [15:0] alu_in_a;
  logic [15:0] alu_in_b;
  logic        alu_carry_in;
  logic [15:0] alu_result;
  logic        alu_carry_out;
  logic        alu_compare;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        flag_carry;
  logic        flag_eq;
  logic        flag_zero;

  always #5 clk = ~clk;

  bitty_alu_sequencer dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .instr_valid_i  (instr_valid),
    .instr_ready_o  (instr_ready),
    .instr_i        (instr),
    .host_we_i      (host_we),
    .host_addr_i    (host_addr),
    .host_wdata_i   (host_wdata),
    .dbg_addr_i     (dbg_addr),
    .dbg_rdata_o    (dbg_rdata),
    .alu_select_o   (alu_select),
    .alu_in_a_o     (alu_in_a),
    .alu_in_b_o     (alu_in_b),
    .alu_carry_in_o (alu_carry_in),
    .alu_result_i   (alu_result),
    .alu_carry_out_i(alu_carry_out),
    .alu_compare_i  (alu_compare),
    .busy_o         (busy),
    .done_o         (done),
    .result_o       (result),
    .flag_carry_o   (flag_carry),
    .flag_eq_o      (flag_eq),
    .flag_zero_o    (flag_zero)
  );

  // Stand-in arithmetic unit; returns {compare, carry, result}.
  function automatic logic [17:0] alu_fn(input logic [3:0] sel, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin);
    logic [16:0] wide;
    logic        eq;
    eq   = (a == b);
    wide = 17'h0;
    case (sel)
      4'd0: wide = {1'b0, a};
      4'd1: wide = {1'b0, b};
      4'd2: wide = {1'b0, a} + {1'b0, b} + {16'h0, cin};
      4'd3: wide = {(a >= b), a - b};
      4'd4: wide = {1'b0, a & b};
      4'd5: wide = {1'b0, a | b};
      4'd6: wide = {1'b0, a ^ b};
      4'd7: wide = {a, cin};
      default: begin
        wide = 17'h0;
        eq   = 1'b0;
      end
    endcase
    return {eq, wide};
  endfunction

  always_comb begin
    {alu_compare, alu_carry_out, alu_result} = alu_fn(alu_select, alu_in_a, alu_in_b,
                                                      alu_carry_in);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one in-flight instruction, tracked by how many edges since it was taken.
  logic [15:0] m_regs [8];
  logic [15:0] m_a, m_b, m_result, m_instr;
  logic [3:0]  m_sel;
  logic        m_cin, m_fc, m_fe, m_fz;
  bit          m_busy;
  int          m_age;
  int          cyc;
  int          acc_cyc[$];
  int          done_seen;
  bit          chk_en;

  initial begin
    cyc = 0;
    m_busy = 0;
    m_age = 0;
    forever begin
      logic [15:0] nregs [8];
      logic [2:0]  rx, ry;
      @(posedge clk);
      cyc++;
      if (reset) begin
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        {m_a, m_b, m_result, m_sel, m_cin, m_fc, m_fe, m_fz} = '0;
        m_busy = 0;
        m_age  = 0;
      end else begin
        nregs = m_regs;
        rx    = m_instr[15:13];
        ry    = m_instr[12:10];
        if (host_we) nregs[host_addr] = host_wdata;
        if (!m_busy) begin
          if (instr_valid) begin
            m_instr = instr;
            m_busy  = 1;
            m_age   = 1;
            acc_cyc.push_back(cyc);
          end
        end else if (m_age == 1) begin
          m_a   = m_regs[rx];
          m_b   = m_regs[ry];
          m_sel = m_instr[9:6];
          m_cin = m_instr[5] & m_fc;
          m_age = 2;
        end else if (m_age == 2) begin
          {m_fe, m_fc, m_result} = alu_fn(m_sel, m_a, m_b, m_cin);
          m_fz  = (m_result == 16'h0);
          m_age = 3;
        end else begin
          if (!m_instr[4]) nregs[rx] = m_result;
          m_busy = 0;
          m_age  = 0;
        end
        m_regs = nregs;
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  initial begin
    done_seen = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("instr_ready", {31'h0, instr_ready}, {31'h0, !m_busy});
        check("busy", {31'h0, busy}, {31'h0, m_busy});
        check("done", {31'h0, done}, {31'h0, (m_busy && m_age == 3)});
        check("alu_select", {28'h0, alu_select}, {28'h0, m_sel});
        check("alu_in_a", {16'h0, alu_in_a}, {16'h0, m_a});
        check("alu_in_b", {16'h0, alu_in_b}, {16'h0, m_b});
        check("alu_carry_in", {31'h0, alu_carry_in}, {31'h0, m_cin});
        check("result", {16'h0, result}, {16'h0, m_result});
        check("flag_carry", {31'h0, flag_carry}, {31'h0, m_fc});
        check("flag_eq", {31'h0, flag_eq}, {31'h0, m_fe});
        check("flag_zero", {31'h0, flag_zero}, {31'h0, m_fz});
        check("dbg_rdata", {16'h0, dbg_rdata}, {16'h0, m_regs[dbg_addr]});
        if (done === 1'b1) done_seen++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [15:0] d);
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    tick();
    host_we    = 1'b0;
  endtask

  function automatic logic [15:0] mk(input logic [2:0] rx, input logic [2:0] ry,
                                     input logic [3:0] sel, input logic uc, input logic nowb);
    return {rx, ry, sel, uc, nowb, 4'h0};
  endfunction

  // Offer an instruction, wait (bounded) for acceptance, return one tick after the accept edge.
  task automatic send(input logic [15:0] ins);
    bit ok;
    ok          = 0;
    instr       = ins;
    instr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (instr_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    check("send_accept", {31'h0, ok}, 32'h1);
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [15:0] exp);
    @(posedge clk);
    #1;
    dbg_addr = a;
    #1;
    check(name, {16'h0, dbg_rdata}, {16'h0, exp});
  endtask

  initial begin
    int d0, a0;
    logic [15:0] list [3];
    logic [31:0] r;
    chk_en      = 0;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0;
    host_we     = 1'b0;
    host_addr   = 3'h0;
    host_wdata  = 16'h0;
    dbg_addr    = 3'h0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1;

    // Reset state
    check("rst_instr_ready", {31'h0, instr_ready}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_flags", {29'h0, flag_carry, flag_eq, flag_zero}, 32'h0);
    for (int i = 0; i < 8; i++) read_check("rst_reg", 3'(i), 16'h0);

    // Add with carry-out
    host_write(3'd1, 16'hFFFF);
    host_write(3'd2, 16'h0001);
    send(mk(3'd1, 3'd2, 4'd2, 1'b0, 1'b0));
    check("ops_ready_low", {31'h0, instr_ready}, 32'h0);
    tick();
    check("add_exec_a", {16'h0, alu_in_a}, 32'hFFFF);
    check("add_exec_b", {16'h0, alu_in_b}, 32'h0001);
    check("exec_busy", {31'h0, busy}, 32'h1);
    tick();
    check("add_done", {31'h0, done}, 32'h1);
    tick();
    check("add_done_gone", {31'h0, done}, 32'h0);
    check("add_flags", {29'h0, flag_carry, flag_eq, flag_zero}, 32'b101);
    read_check("add_r1", 3'd1, 16'h0000);

    // Carry chaining
    host_write(3'd3, 16'h0004);
    host_write(3'd4, 16'h0005);
    send(mk(3'd3, 3'd4, 4'd2, 1'b1, 1'b0));
    tick();
    check("chain_cin", {31'h0, alu_carry_in}, 32'h1);
    repeat (2) tick();
    check("chain_fc", {31'h0, flag_carry}, 32'h0);
    read_check("chain_r3", 3'd3, 16'h000A);

    // Compare-only
    host_write(3'd5, 16'h1234);
    host_write(3'd6, 16'h1234);
    d0 = done_seen;
    send(mk(3'd5, 3'd6, 4'd3, 1'b0, 1'b1));
    repeat (3) tick();
    check("cmp_eq", {31'h0, flag_eq}, 32'h1);
    check("cmp_done_once", d0 + 1, done_seen);
    read_check("cmp_r5", 3'd5, 16'h1234);

    // Back-to-back with instr_valid held high
    list[0] = mk(3'd2, 3'd4, 4'd2, 1'b0, 1'b0);
    list[1] = mk(3'd4, 3'd2, 4'd4, 1'b0, 1'b0);
    list[2] = mk(3'd3, 3'd3, 4'd6, 1'b0, 1'b0);
    a0 = acc_cyc.size();
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bit ok;
      ok    = 0;
      instr = list[k];
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (instr_ready === 1'b1) begin
          ok = 1;
          break;
        end
      end
      check("b2b_accept", {31'h0, ok}, 32'h1);
      tick();
    end
    instr_valid = 1'b0;
    repeat (3) tick();
    check("b2b_count", acc_cyc.size(), a0 + 3);
    if (acc_cyc.size() == a0 + 3) begin
      check("b2b_gap1", acc_cyc[a0 + 1] - acc_cyc[a0], 4);
      check("b2b_gap2", acc_cyc[a0 + 2] - acc_cyc[a0 + 1], 4);
    end
    read_check("b2b_r2", 3'd2, 16'h0006);
    read_check("b2b_r4", 3'd4, 16'h0004);
    read_check("b2b_r3", 3'd3, 16'h0000);

    // Reset during EXEC aborts the instruction
    host_write(3'd0, 16'h0010);
    d0 = done_seen;
    send(mk(3'd0, 3'd0, 4'd7, 1'b0, 1'b0));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ready", {31'h0, instr_ready}, 32'h1);
    repeat (3) tick();
    check("abort_no_done", done_seen, d0);
    read_check("abort_r0", 3'd0, 16'h0000);

    // Host write to ry during OPS, host write colliding with WB
    host_write(3'd1, 16'h0007);
    host_write(3'd2, 16'h0003);
    send(mk(3'd1, 3'd2, 4'd2, 1'b0, 1'b0));
    host_we = 1'b1; host_addr = 3'd2; host_wdata = 16'h0100;
    tick();
    host_we = 1'b0;
    tick();
    host_we = 1'b1; host_addr = 3'd1; host_wdata = 16'hBEEF;
    tick();
    host_we = 1'b0;
    read_check("coll_r1", 3'd1, 16'h000A);
    read_check("ops_host_r2", 3'd2, 16'h0100);

    // Upper select values return zero
    host_write(3'd4, 16'h0055);
    send(mk(3'd4, 3'd1, 4'd9, 1'b0, 1'b0));
    repeat (3) tick();
    check("sel9_flags", {29'h0, flag_carry, flag_eq, flag_zero}, 32'b001);
    read_check("sel9_r4", 3'd4, 16'h0000);

    // Randomized phase
    for (int n = 0; n < 1500; n++) begin
      r           = $urandom;
      reset       = ($urandom_range(0, 99) == 0);
      instr_valid = r[31];
      instr       = r[15:0];
      host_we     = ($urandom_range(0, 3) == 0);
      host_addr   = r[18:16];
      dbg_addr    = r[21:19];
      r           = $urandom;
      case (r[17:16])
        2'd0: host_wdata = 16'h0000;
        2'd1: host_wdata = 16'hFFFF;
        default: host_wdata = r[15:0];
      endcase
      tick();
    end
    reset       = 1'b0;
    instr_valid = 1'b0;
    host_we     = 1'b0;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
